ram_arbiter: RTL and testbench

- Round-robin arbiter that shares the single RAM port between CPUS cores, each presenting one instruction and one data request channel.
- Sits between the per-core cache control interfaces and the RAM model, in place of the single-core pass-through.
- Serialises word accesses: registered grant, one transaction in flight, fair rotation across cores.
- Coherence snooping is out of scope; a separate block owns it.

---
 rtl/cpu_types_pkg.sv | 18 +
 rtl/ram_arbiter_if.sv | 37 +++
 rtl/rr_picker.sv | 28 ++
 rtl/ram_arbiter.sv | 103 ++++++++++
 tb/tb_ram_arbiter.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU/RAM types: word, RAM handshake state and the RAM arbiter FSM state.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE,
      BUSY,
      ACCESS,
      ERROR
   } ramstate_t;

   typedef enum logic {
      IDLE,
      GRANT
   } arb_state_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bus bundle between the per-core cache controllers, the RAM arbiter and the RAM model.
interface ram_arbiter_if #(
   parameter int CPUS = 2
);
   import cpu_types_pkg::*;

   logic [CPUS-1:0]  iREN;
   logic [CPUS-1:0]  dREN;
   logic [CPUS-1:0]  dWEN;
   word_t [CPUS-1:0] iaddr;
   word_t [CPUS-1:0] daddr;
   word_t [CPUS-1:0] dstore;
   logic [CPUS-1:0]  iwait;
   logic [CPUS-1:0]  dwait;
   word_t [CPUS-1:0] iload;
   word_t [CPUS-1:0] dload;

   logic             ramREN;
   logic             ramWEN;
   word_t            ramaddr;
   word_t            ramstore;
   word_t            ramload;
   ramstate_t        ramstate;

   // Cores plus RAM model side.
   modport master (
      output iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
      input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
   );

   // Arbiter side.
   modport slave (
      input  iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
      output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
   );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester at or after rr_ptr+1, wrapping.
module rr_picker #(
   parameter int N  = 2,
   parameter int CW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [CW-1:0] rr_ptr,
   output logic          valid,
   output logic [CW-1:0] index
);

   logic [CW-1:0] pos;

   always_comb begin
      valid = 1'b0;
      index = '0;
      pos   = '0;
      // k runs 1..N so the previous winner (rr_ptr) is considered last.
      for (int k = 1; k <= N; k++) begin
         pos = CW'((int'(rr_ptr) + k) % N);
         if (!valid && req[pos]) begin
            valid = 1'b1;
            index = pos;
         end
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one RAM port among CPUS cores' instruction and data channels.
module ram_arbiter
   import cpu_types_pkg::*;
#(
   parameter int CPUS = 2,
   parameter int CW   = $clog2(CPUS)
) (
   input logic          CLK,
   input logic          nRST,
   ram_arbiter_if.slave bus
);

   arb_state_t      state_q, state_d;
   logic [CW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]   gnt_core_q, gnt_core_d;
   logic            gnt_is_d_q, gnt_is_d_d;

   logic [CPUS-1:0] core_req;
   logic            pick_valid;
   logic [CW-1:0]   pick_idx;
   logic            live_req;
   logic            done;

   assign core_req = bus.iREN | bus.dREN | bus.dWEN;

   rr_picker #(
      .N  (CPUS),
      .CW (CW)
   ) u_picker (
      .req    (core_req),
      .rr_ptr (rr_ptr_q),
      .valid  (pick_valid),
      .index  (pick_idx)
   );

   assign bus.iload = {CPUS{bus.ramload}};
   assign bus.dload = {CPUS{bus.ramload}};

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q    <= IDLE;
         rr_ptr_q   <= CW'(CPUS - 1);
         gnt_core_q <= '0;
         gnt_is_d_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         gnt_core_q <= gnt_core_d;
         gnt_is_d_q <= gnt_is_d_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      gnt_core_d   = gnt_core_q;
      gnt_is_d_d   = gnt_is_d_q;
      bus.ramREN   = 1'b0;
      bus.ramWEN   = 1'b0;
      bus.ramaddr  = '0;
      bus.ramstore = '0;
      bus.iwait    = '1;
      bus.dwait    = '1;
      live_req     = 1'b0;
      done         = 1'b0;

      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               state_d    = GRANT;
               gnt_core_d = pick_idx;
               // Data beats instruction within a core.
               gnt_is_d_d = bus.dREN[pick_idx] | bus.dWEN[pick_idx];
            end
         end
         GRANT: begin
            if (gnt_is_d_q) begin
               bus.ramaddr  = bus.daddr[gnt_core_q];
               bus.ramstore = bus.dstore[gnt_core_q];
               bus.ramWEN   = bus.dWEN[gnt_core_q];
               bus.ramREN   = bus.dREN[gnt_core_q] & ~bus.dWEN[gnt_core_q];
               live_req     = bus.dREN[gnt_core_q] | bus.dWEN[gnt_core_q];
            end else begin
               bus.ramaddr  = bus.iaddr[gnt_core_q];
               bus.ramREN   = bus.iREN[gnt_core_q];
               live_req     = bus.iREN[gnt_core_q];
            end
            done = live_req && (bus.ramstate == ACCESS);
            if (done) begin
               if (gnt_is_d_q) bus.dwait[gnt_core_q] = 1'b0;
               else            bus.iwait[gnt_core_q] = 1'b0;
               state_d  = IDLE;
               rr_ptr_d = gnt_core_q;
            end else if (!live_req || bus.ramstate == ERROR) begin
               // Pointer untouched so an errored or withdrawn core keeps its turn.
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus random traffic vs a cycle model.
module tb_ram_arbiter;
   import cpu_types_pkg::*;

   localparam int CPUS = 2;
   localparam int CW   = $clog2(CPUS);

   logic CLK = 1'b0;
   logic nRST;
   always #5 CLK = ~CLK;

   ram_arbiter_if #(.CPUS(CPUS)) bus ();

   ram_arbiter #(
      .CPUS (CPUS),
      .CW   (CW)
   ) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus)
   );

   int ntests = 0;
   int nfail  = 0;

   // Reference model: one transaction in flight, identified by core and channel.
   logic m_busy;
   logic m_isd;
   int   m_core;
   int   m_ptr;

   logic             obs_ren, obs_wen;
   word_t            obs_addr, obs_store;
   logic [CPUS-1:0]  obs_iw, obs_dw;
   word_t [CPUS-1:0] obs_iload;

   logic [1:0] fair_dw [8] = '{2'b11, 2'b10, 2'b11, 2'b01, 2'b11, 2'b10, 2'b11, 2'b01};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int rr_pick(input logic [CPUS-1:0] req, input int ptr);
      for (int k = 1; k <= CPUS; k++) begin
         if (req[(ptr + k) % CPUS]) return (ptr + k) % CPUS;
      end
      return -1;
   endfunction

   task automatic clear_reqs();
      bus.iREN = '0;
      bus.dREN = '0;
      bus.dWEN = '0;
   endtask

   // Check one cycle at the falling edge, advance the model, return at posedge+1.
   task automatic step(input string tag);
      logic            exp_ren, exp_wen, live, done;
      word_t           exp_addr, exp_store;
      logic [CPUS-1:0] exp_iw, exp_dw, req;
      int              pick;
      @(negedge CLK);
      exp_ren = 1'b0; exp_wen = 1'b0; exp_addr = '0; exp_store = '0;
      exp_iw = '1; exp_dw = '1; live = 1'b0; done = 1'b0;
      if (m_busy) begin
         if (m_isd) begin
            exp_addr  = bus.daddr[m_core];
            exp_store = bus.dstore[m_core];
            exp_wen   = bus.dWEN[m_core];
            exp_ren   = bus.dREN[m_core] & ~bus.dWEN[m_core];
            live      = bus.dREN[m_core] | bus.dWEN[m_core];
         end else begin
            exp_addr = bus.iaddr[m_core];
            exp_ren  = bus.iREN[m_core];
            live     = bus.iREN[m_core];
         end
         done = live && (bus.ramstate == ACCESS);
         if (done) begin
            if (m_isd) exp_dw[m_core] = 1'b0;
            else       exp_iw[m_core] = 1'b0;
         end
      end
      obs_ren = bus.ramREN; obs_wen = bus.ramWEN; obs_addr = bus.ramaddr;
      obs_store = bus.ramstore; obs_iw = bus.iwait; obs_dw = bus.dwait; obs_iload = bus.iload;
      chk($sformatf("%s.ramREN", tag), obs_ren, exp_ren);
      chk($sformatf("%s.ramWEN", tag), obs_wen, exp_wen);
      chk($sformatf("%s.ramaddr", tag), obs_addr, exp_addr);
      chk($sformatf("%s.ramstore", tag), obs_store, exp_store);
      chk($sformatf("%s.iwait", tag), obs_iw, exp_iw);
      chk($sformatf("%s.dwait", tag), obs_dw, exp_dw);
      chk($sformatf("%s.iload", tag), obs_iload, {CPUS{bus.ramload}});
      chk($sformatf("%s.dload", tag), bus.dload, {CPUS{bus.ramload}});
      chk($sformatf("%s.onelow", tag), $countones({~obs_iw, ~obs_dw}) > 1, 1'b0);
      if (!m_busy) begin
         req  = bus.iREN | bus.dREN | bus.dWEN;
         pick = rr_pick(req, m_ptr);
         if (pick >= 0) begin
            m_busy = 1'b1;
            m_core = pick;
            m_isd  = bus.dREN[pick] | bus.dWEN[pick];
         end
      end else if (done) begin
         m_busy = 1'b0;
         m_ptr  = m_core;
      end else if (!live || bus.ramstate == ERROR) begin
         m_busy = 1'b0;
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      @(negedge CLK);
      nRST = 1'b0;
      #1;
      chk("rst.ramREN", bus.ramREN, 1'b0);
      chk("rst.ramWEN", bus.ramWEN, 1'b0);
      chk("rst.ramaddr", bus.ramaddr, 32'h0);
      chk("rst.ramstore", bus.ramstore, 32'h0);
      chk("rst.iwait", bus.iwait, {CPUS{1'b1}});
      chk("rst.dwait", bus.dwait, {CPUS{1'b1}});
      m_busy = 1'b0; m_isd = 1'b0; m_core = 0; m_ptr = CPUS - 1;
      @(posedge CLK);
      @(negedge CLK);
      nRST = 1'b1;
      @(posedge CLK);
      #1;
   endtask

   initial begin
      nRST = 1'b0;
      clear_reqs();
      bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0;
      bus.ramload = '0; bus.ramstate = FREE;
      do_reset();

      // Single instruction fetch, ACCESS on the second GRANT cycle.
      bus.iREN = 2'b01; bus.iaddr[0] = 32'h100; bus.ramstate = BUSY;
      step("fetch.arb");
      step("fetch.busy");
      chk("fetch.ramREN", obs_ren, 1'b1);
      chk("fetch.ramaddr", obs_addr, 32'h100);
      bus.ramstate = ACCESS; bus.ramload = 32'hDEADBEEF;
      step("fetch.acc");
      chk("fetch.iwait_low", obs_iw, 2'b10);
      chk("fetch.iload0", obs_iload[0], 32'hDEADBEEF);
      bus.iREN = '0; bus.ramstate = FREE;
      step("fetch.after");
      chk("fetch.iwait_pulse", obs_iw, 2'b11);

      // Same-core priority: write first, fetch after one IDLE bubble.
      bus.iREN = 2'b10; bus.dWEN = 2'b10; bus.iaddr[1] = 32'h300;
      bus.daddr[1] = 32'h200; bus.dstore[1] = 32'h12345678; bus.ramstate = ACCESS;
      step("prio.arb");
      step("prio.wr");
      chk("prio.ramWEN", obs_wen, 1'b1);
      chk("prio.ramREN", obs_ren, 1'b0);
      chk("prio.ramaddr", obs_addr, 32'h200);
      chk("prio.ramstore", obs_store, 32'h12345678);
      chk("prio.dwait", obs_dw, 2'b01);
      bus.dWEN = '0;
      step("prio.bubble");
      chk("prio.bubble_waits", {obs_iw, obs_dw}, 4'b1111);
      step("prio.fetch");
      chk("prio.fetch_iwait", obs_iw, 2'b01);
      chk("prio.fetch_addr", obs_addr, 32'h300);
      clear_reqs();
      step("prio.end");

      // Fairness under contention, starting from reset.
      do_reset();
      bus.dREN = 2'b11; bus.ramstate = ACCESS;
      for (int i = 0; i < 8; i++) begin
         step("fair");
         chk($sformatf("fair.dwait%0d", i), obs_dw, fair_dw[i]);
      end
      clear_reqs();
      step("fair.end");

      // ERROR retry: put the pointer on core0, then core1 errors and keeps its turn.
      bus.dREN = 2'b01;
      step("err.pre_arb");
      step("err.pre_acc");
      bus.dREN = 2'b10;
      step("err.arb");
      bus.ramstate = ERROR;
      step("err.err");
      chk("err.dwait_high", obs_dw, 2'b11);
      bus.dREN = 2'b11; bus.ramstate = ACCESS;
      step("err.rearb");
      step("err.retry");
      chk("err.retry_core1", obs_dw, 2'b01);
      bus.dREN = 2'b01;
      step("err.arb0");
      step("err.acc0");
      clear_reqs();
      step("err.end");

      // Withdrawal: core1 drops its request; the pointer must not move.
      bus.dREN = 2'b10; bus.ramstate = BUSY;
      step("wd.arb");
      step("wd.grant");
      chk("wd.ramREN", obs_ren, 1'b1);
      bus.dREN = '0;
      step("wd.drop");
      chk("wd.waits", {obs_iw, obs_dw}, 4'b1111);
      bus.dREN = 2'b11; bus.ramstate = ACCESS;
      step("wd.rearb");
      step("wd.next");
      chk("wd.core1_again", obs_dw, 2'b01);
      clear_reqs();
      step("wd.end");

      // Reset while a write is in GRANT.
      bus.dWEN = 2'b01; bus.dstore[0] = 32'hCAFE0001; bus.ramstate = BUSY;
      step("rstg.arb");
      step("rstg.grant");
      chk("rstg.ramWEN_before", obs_wen, 1'b1);
      #2;
      nRST = 1'b0;
      #1;
      chk("rstg.ramWEN", bus.ramWEN, 1'b0);
      chk("rstg.ramREN", bus.ramREN, 1'b0);
      chk("rstg.waits", {bus.iwait, bus.dwait}, 4'b1111);
      m_busy = 1'b0; m_ptr = CPUS - 1;
      clear_reqs();
      @(negedge CLK);
      nRST = 1'b1;
      @(posedge CLK);
      #1;

      // Random traffic against the model.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0) bus.iREN = CPUS'($urandom);
         if ($urandom_range(0, 3) == 0) bus.dREN = CPUS'($urandom);
         if ($urandom_range(0, 5) == 0) bus.dWEN = CPUS'($urandom);
         for (int c = 0; c < CPUS; c++) begin
            bus.iaddr[c]  = $urandom;
            bus.daddr[c]  = $urandom;
            bus.dstore[c] = $urandom;
         end
         case ($urandom_range(0, 9))
            0:       bus.ramstate = FREE;
            1, 2:    bus.ramstate = BUSY;
            9:       bus.ramstate = ERROR;
            default: bus.ramstate = ACCESS;
         endcase
         bus.ramload = $urandom;
         step("rand");
      end

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
